// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder, LSB-first, WIDTH cycles per add.
// A/B shift right through the adder, the sum bits shift into a result register
// from the MSB side, and sum/cout are only updated when an add completes.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH must be in 1..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH:0]   res_ext;

    // The only adder in the block: consumes the current LSBs and running carry.
    full_adder u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (c_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // New sum bit enters at the top; slicing [WIDTH:1] is the shifted result
    // and stays legal when WIDTH is 1.
    assign res_ext = {fa_s, res_q};

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                // clr wins over a simultaneous start.
                if (start && !clr) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    c_d     = cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clr) begin
                    // Abort: drop the partial result, outputs keep the old value.
                    state_d = IDLE;
                end else begin
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    c_d   = fa_co;
                    res_d = res_ext[WIDTH:1];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        // Last bit: publish the finished result including this bit.
                        sum_d   = res_ext[WIDTH:1];
                        cout_d  = fa_co;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         sys_clk;
    logic         sys_rst_n;
    logic         start;
    logic         clr;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .clr       (clr),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance one edge; outputs are observed 1 time unit after it.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Issue a one-cycle start and wait for done (bounded). lat counts cycles
    // from the start cycle (cycle 0) to the done cycle; -1 on timeout.
    // Ends one cycle after done so a following start lands in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, output int lat, output int bcnt,
                          output logic moved, output logic tail_done,
                          output logic tail_busy);
        logic [W-1:0] s0;
        s0    = sum;
        moved = 1'b0;
        op_a = a; op_b = b; cin = c; start = 1'b1;
        step();
        start = 1'b0;
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            if (sum !== s0) moved = 1'b1;
            step();
            lat++;
            if (busy) bcnt++;
        end
        if (!done) lat = -1;
        step();
        tail_done = done;
        tail_busy = busy;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; start = 1'b0; clr = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0;
        step(); step();
        n_checks++;
        if ({busy, done, cout, sum} !== {3'b000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b cout=%b sum=%h expected 0 0 0 00",
                     busy, done, cout, sum);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        logic moved, td, tb;
        sys_rst_n = 1'b1;   // start on the very first released edge
        run_op(8'h5A, 8'h3C, 1'b0, lat, bcnt, moved, td, tb);
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d expected 9", lat); end
        n_checks++;
        if (bcnt !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 8", bcnt); end
        n_checks++;
        if ({cout, sum} !== 9'h096) begin
            n_fail++; $display("FAIL basic_result: got %b_%h expected 0_96", cout, sum);
        end
        n_checks++;
        if (moved !== 1'b0) begin n_fail++; $display("FAIL basic_sum_hold_in_run: sum changed before done"); end
        n_checks++;
        if ({td, tb} !== 2'b00) begin
            n_fail++; $display("FAIL basic_done_pulse: after done got done=%b busy=%b expected 0 0", td, tb);
        end
    endtask

    task automatic test_carry();
        int lat, bcnt;
        logic moved, td, tb;
        run_op(8'hFF, 8'h01, 1'b0, lat, bcnt, moved, td, tb);
        n_checks++;
        if ({cout, sum} !== 9'h100) begin
            n_fail++; $display("FAIL carry_ff_01: got %b_%h expected 1_00", cout, sum);
        end
        run_op(8'hFF, 8'hFF, 1'b1, lat, bcnt, moved, td, tb);
        n_checks++;
        if ({cout, sum} !== 9'h1FF) begin
            n_fail++; $display("FAIL carry_ff_ff_c1: got %b_%h expected 1_ff", cout, sum);
        end
        run_op(8'h00, 8'h00, 1'b1, lat, bcnt, moved, td, tb);
        n_checks++;
        if ({cout, sum} !== 9'h001) begin
            n_fail++; $display("FAIL carry_cin_only: got %b_%h expected 0_01", cout, sum);
        end
        run_op(8'h80, 8'h80, 1'b0, lat, bcnt, moved, td, tb);
        n_checks++;
        if ({cout, sum} !== 9'h100) begin
            n_fail++; $display("FAIL carry_msb: got %b_%h expected 1_00", cout, sum);
        end
    endtask

    task automatic test_start_busy();
        int dcnt = 0, bcnt = 0, dcyc = -1;
        op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
        step();                         // accept; now in RUN cycle 1
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (done) begin dcnt++; dcyc = cyc; end
            if (busy) bcnt++;
            start = (cyc == 3 || cyc == 8 || cyc == 9);
            op_a  = 8'hAA; op_b = 8'h11; cin = 1'b1;
            step();
        end
        start = 1'b0;
        n_checks++;
        if (dcnt !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 1", dcnt); end
        n_checks++;
        if (dcyc !== 9) begin n_fail++; $display("FAIL busy_done_cycle: got %0d expected 9", dcyc); end
        n_checks++;
        if (bcnt !== 8) begin n_fail++; $display("FAIL busy_no_requeue: busy cycles %0d expected 8", bcnt); end
        n_checks++;
        if ({cout, sum} !== 9'h046) begin
            n_fail++; $display("FAIL busy_result: got %b_%h expected 0_46", cout, sum);
        end
    endtask

    task automatic test_clr();
        int lat, bcnt, dcnt;
        logic moved, td, tb;
        run_op(8'h5A, 8'h3C, 1'b0, lat, bcnt, moved, td, tb);
        op_a = 8'h01; op_b = 8'h01; cin = 1'b0; start = 1'b1;
        step();                         // RUN cycle 1
        start = 1'b0;
        step(); step(); step();         // RUN cycle 4
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL clr_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dcnt++;
            step();
        end
        n_checks++;
        if (dcnt !== 0) begin n_fail++; $display("FAIL clr_no_done: got %0d pulses expected 0", dcnt); end
        n_checks++;
        if ({cout, sum} !== 9'h096) begin
            n_fail++; $display("FAIL clr_sum_hold: got %b_%h expected 0_96", cout, sum);
        end
        // clr together with start in IDLE keeps the block idle
        start = 1'b1; clr = 1'b1;
        step();
        start = 1'b0; clr = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_start_priority: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, dcnt;
        logic moved, td, tb;
        op_a = 8'h33; op_b = 8'h44; cin = 1'b0; start = 1'b1;
        step();                         // RUN cycle 1
        start = 1'b0;
        step(); step(); step(); step(); // RUN cycle 5
        sys_rst_n = 1'b0;
        step();
        n_checks++;
        if ({busy, done, cout, sum} !== {3'b000, 8'h00}) begin
            n_fail++;
            $display("FAIL rst_mid_state: got busy=%b done=%b cout=%b sum=%h expected 0 0 0 00",
                     busy, done, cout, sum);
        end
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) dcnt++;
        end
        n_checks++;
        if (dcnt !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", dcnt); end
        sys_rst_n = 1'b1;
        run_op(8'h10, 8'h20, 1'b0, lat, bcnt, moved, td, tb);
        n_checks++;
        if (lat !== 9 || {cout, sum} !== 9'h030) begin
            n_fail++; $display("FAIL rst_mid_recover: got lat=%0d %b_%h expected 9 0_30", lat, cout, sum);
        end
    endtask

    task automatic test_back_to_back();
        int dc[$];
        op_a = 8'h01; op_b = 8'h02; cin = 1'b0; start = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            step();
            if (done) dc.push_back(i);
        end
        start = 1'b0;
        n_checks++;
        if (dc.size() !== 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d pulses expected 3", dc.size());
        end else begin
            n_checks++;
            if (dc[0] !== 9 || dc[1] - dc[0] !== 10 || dc[2] - dc[1] !== 10) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d,%0d,%0d expected 9,19,29", dc[0], dc[1], dc[2]);
            end
        end
        n_checks++;
        if ({cout, sum} !== 9'h003) begin
            n_fail++; $display("FAIL b2b_result: got %b_%h expected 0_03", cout, sum);
        end
        for (int i = 0; i < 12; i++) step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_busy();
        test_clr();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; the legal range is 1..32.
REQ-002 The block SHALL have port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port sys_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous abort of an operation in progress.
REQ-006 The block SHALL have port op_a, input, WIDTH bits: addend A; sampled on the start-accept edge only.
REQ-007 The block SHALL have port op_b, input, WIDTH bits: addend B; sampled on the start-accept edge only.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in; sampled on the start-accept edge only.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse, high while in DONE.
REQ-011 The block SHALL have port sum, output, WIDTH bits: result of the last completed addition.
REQ-012 The block SHALL have port cout, output, 1 bit: carry-out of the last completed addition.

Function
REQ-013 The block SHALL contain exactly one full_adder instance, and that instance SHALL be its only addition logic; the datapath is bit-serial, LSB first.
REQ-014 The block SHALL implement a state machine with states IDLE, RUN and DONE; the state SHALL be IDLE out of reset.
REQ-015 In IDLE, the block SHALL treat start=1 at an edge as acceptance:
- latch op_a, op_b and cin into shift/carry registers;
- clear the bit counter to 0;
- go to RUN.
REQ-016 Each RUN cycle SHALL process exactly one bit:
- full_adder inputs are the LSBs of the A/B shift registers plus the carry register;
- on the edge, its sum bit shifts into the MSB of the result shift register;
- its carry is stored in the carry register;
- the A/B registers shift right;
- the counter increments.
REQ-017 The block SHALL leave RUN after exactly WIDTH cycles: on the edge where the counter equals WIDTH-1, it goes to DONE and loads the sum/cout outputs from the result and carry registers.
REQ-018 The block SHALL stay in DONE for exactly one cycle, then return to IDLE unconditionally.
REQ-019 The start-accept edge to the first cycle with done=1 SHALL take WIDTH+1 cycles, and a new start SHALL be accepted no earlier than the cycle after done.
REQ-020 The block SHALL ignore start while in RUN or DONE; such a request is not queued.
REQ-021 sum and cout SHALL change only on entry to DONE and SHALL otherwise hold their last value, including throughout RUN and after clr.
REQ-022 clr=1 in RUN SHALL return the block to IDLE on that edge, with no done pulse and no sum/cout update.
REQ-023 clr=1 in IDLE or DONE SHALL have no effect.
REQ-024 clr=1 together with start=1 in IDLE SHALL leave the block in IDLE; clr has priority.
REQ-025 Results SHALL be exact: {cout,sum} = op_a + op_b + cin, computed at WIDTH+1 bits.
REQ-026 The counter SHALL be sized to hold WIDTH-1; with WIDTH=1, RUN SHALL last one cycle.

Reset
REQ-027 sys_rst_n=0 at an edge SHALL force the following values, taking priority over all other inputs:
- state=IDLE;
- busy=0, done=0;
- sum=0, cout=0;
- counter and all internal registers = 0.
REQ-028 A reset asserted mid-RUN SHALL discard the operation without producing a done pulse.
REQ-029 The first start SHALL be accepted on the first edge with sys_rst_n=1.

Verification (WIDTH=8)
REQ-030 The bench SHALL cover a basic addition:
- stimulus: op_a=0x5A, op_b=0x3C, cin=0, start for 1 cycle;
- response: busy high for 8 cycles, done high 9 cycles after accept, sum=0x96, cout=0.
REQ-031 The bench SHALL cover carry wrap-around:
- stimulus: 0xFF + 0x01, cin=0;
- response: sum=0x00, cout=1.
- stimulus: 0xFF + 0xFF, cin=1;
- response: sum=0xFF, cout=1.
REQ-032 The bench SHALL cover start while busy:
- stimulus: start pulsed on RUN cycles 3 and 8, and in DONE, with different operands;
- response: only the first operation completes, exactly one done pulse, and the next accept only occurs from IDLE.
REQ-033 The bench SHALL cover abort:
- stimulus: clr=1 on RUN cycle 4 after a prior result of 0x96;
- response: IDLE next cycle, no done pulse, sum stays 0x96.
REQ-034 The bench SHALL cover reset mid-operation:
- stimulus: sys_rst_n=0 on RUN cycle 5;
- response: busy=0, done=0, sum=0x00, cout=0 on the next cycle;
- after release, a new start with 0x10 + 0x20 completes to 0x30.
REQ-035 The bench SHALL cover back-to-back operations:
- stimulus: start held high continuously;
- response: operations accepted every 10 cycles, with done pulses 10 cycles apart.
